// File: rtl/pipe_stage_buf_pkg.sv
// Shared defaults and width helpers for the elastic pipeline-stage buffer.
// Pointer/count widths are derived from DEPTH so each boundary sizes itself.
package pipe_stage_buf_pkg;

    localparam int PSB_DATA_W_DEF = 32;
    localparam int PSB_DEPTH_DEF  = 2;

    function automatic int psb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int psb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular queue, flush drops all, NOP payload when empty.
// Latency: payload accepted at edge N is on out_data/out_valid after edge N; no in->out bypass.
// Backpressure: in_ready falls only when full and is computed from registered count alone.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                 DATA_W   = PSB_DATA_W_DEF,
    parameter int                 DEPTH    = PSB_DEPTH_DEF,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = psb_ptr_w(DEPTH);
    localparam int CNT_W = psb_cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic push;
    logic pop;

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : NOP_DATA;
    assign occupancy = count_q;

    // Flush outranks both handshakes; rdy low freezes everything including flush.
    assign push = rdy & in_valid  & in_ready  & ~flush;
    assign pop  = rdy & out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rdy && flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents are never visible while empty, so the array carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized and directed bench for pipe_stage_buf with a queue reference model and output scoreboard.
module tb_pipe_stage_buf;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        rdy       = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];

    pipe_stage_buf #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NOP_DATA (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of accepted payloads, updated at each active edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            exp_q.delete();
        end else if (rdy) begin
            if (flush) begin
                model_q.delete();
                exp_q.delete();
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (model_q.size() != 0) && out_ready;
                do_push = in_valid && (model_q.size() < DEPTH);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    model_q.push_back(in_data);
                    exp_q.push_back(in_data);
                end
            end
        end
    end

    // Monitor: state checks every cycle, scoreboard pop on each output handshake.
    always @(negedge clk) begin
        logic [31:0] want;
        want = (model_q.size() != 0) ? model_q[0] : NOP;
        chk("occupancy", 32'(occupancy), 32'(model_q.size()));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        chk("out_data",  out_data, want);
        if (rst_n && rdy && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no output at %0t", out_data, $time);
            end else begin
                chk("scoreboard", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] d, input logic o);
        rdy       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data, NOP);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 32'(i), 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        // Fill to full, hold E upstream, then drain; twice for pointer wrap.
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 32'hA0 + 32'(rep * 16 + k), 1'b0);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            step(1'b1, 1'b0, 1'b1, 32'hA4 + 32'(rep * 16), 1'b1);
            chk("pop_frees_slot", 32'(in_ready), 32'd1);
            step(1'b1, 1'b0, 1'b1, 32'hA4 + 32'(rep * 16), 1'b1);
            repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Flush beats a simultaneous push and pop.
        step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("flush_occ",  32'(occupancy), 32'd0);
        chk("flush_data", out_data, NOP);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        // rdy low freezes state even with flush asserted.
        step(1'b1, 1'b0, 1'b1, 32'h5A5A_0001, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, 1'b1);
        chk("gated_occ",  32'(occupancy), 32'd1);
        chk("gated_data", out_data, 32'h5A5A_0001);
        step(1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD, 1'b1);
        chk("resume_flush_occ", 32'(occupancy), 32'd0);

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
        end
        repeat (DEPTH + 2) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        // Asynchronous reset between edges with three entries held.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 32'hC0 + 32'(k), 1'b0);
        chk("pre_reset_occ", 32'(occupancy), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ",       32'(occupancy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_data",  out_data, NOP);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1);
        repeat (DEPTH + 2) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
